iob_cache_nport_arbiter: RTL and testbench

N-port IOb native front-end arbiter that lets several processing elements (e.g. instruction and data ports of a CPU, plus DMA) share one cache front-end port. It sits between the masters and the cache top-level `req/addr/wdata/wstrb/rdata/ack` port. It serialises requests with round-robin or fixed priority. It holds a captured copy of the granted request until the cache acknowledges, then routes `rdata`/`ack` back to the owning port.

---
 rtl/iob_cache_nport_arbiter_pkg.sv | 17 +
 rtl/iob_cache_rr_arbiter.sv | 41 ++++
 rtl/iob_cache_nport_arbiter.sv | 132 +++++++++++++
 tb/tb_iob_cache_nport_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_cache_nport_arbiter_pkg.sv
// Shared types and constants for the N-port cache front-end arbiter.
package iob_cache_nport_arbiter_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for a single port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_cache_rr_arbiter.sv
// Combinational rotating-priority select: double-width masked priority encoder.
module iob_cache_rr_arbiter
  import iob_cache_nport_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned IDX_W   = clog2_min1(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  input  logic               mode,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  localparam int NP  = int'(N_PORTS);
  localparam int DBL = 2 * NP;

  logic [DBL-1:0] dbl_req;
  logic [DBL-1:0] masked;
  int             start;

  always_comb begin
    start = 0;
    if (!mode && (int'(last) + 1) < NP) begin
      start = int'(last) + 1;
    end
    dbl_req = {req, req};
    for (int i = 0; i < DBL; i++) begin
      masked[i] = dbl_req[i] && (i >= start);
    end
    gnt_valid = |req;
    gnt_idx   = '0;
    // Scan downwards so the lowest set bit at or above start wins.
    for (int i = DBL - 1; i >= 0; i--) begin
      if (masked[i]) begin
        gnt_idx = (i >= NP) ? IDX_W'(i - NP) : IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/iob_cache_nport_arbiter.sv
// Shares one IOb cache front-end port among N masters; holds the granted request until ack.
module iob_cache_nport_arbiter
  import iob_cache_nport_arbiter_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            s_req,
  input  logic [N_PORTS*ADDR_W-1:0]     s_addr,
  input  logic [N_PORTS*DATA_W-1:0]     s_wdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0] s_wstrb,
  output logic [N_PORTS*DATA_W-1:0]     s_rdata,
  output logic [N_PORTS-1:0]            s_ack,
  output logic                          m_req,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic                          m_ack
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDX_W  = clog2_min1(N_PORTS);
  localparam logic        MODE   = (PRIO_MODE == ARB_FIXED);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [NBYTES-1:0]  sel_wstrb;
  logic [ADDR_W-1:0]  cap_addr;
  logic [DATA_W-1:0]  cap_wdata;
  logic [NBYTES-1:0]  cap_wstrb;

  iob_cache_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (s_req),
    .last      (last),
    .mode      (MODE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Winner field mux.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        sel_wstrb = s_wstrb[i*NBYTES +: NBYTES];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture and round-robin history, updated on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= '0;
      last      <= IDX_W'(N_PORTS - 1);
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else if (state == ST_IDLE && gnt_valid) begin
      owner     <= gnt_idx;
      last      <= gnt_idx;
      cap_addr  <= sel_addr;
      cap_wdata <= sel_wdata;
      cap_wstrb <= sel_wstrb;
    end
  end

  // Outputs are forced quiet during reset so an aborted transfer never acks.
  always_comb begin
    state_nxt = state;
    m_req     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    s_ack     = '0;
    s_rdata   = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            m_req     = 1'b1;
            m_addr    = sel_addr;
            m_wdata   = sel_wdata;
            m_wstrb   = sel_wstrb;
            state_nxt = ST_BUSY;
          end
        end
        ST_BUSY: begin
          m_req   = ~m_ack;
          m_addr  = cap_addr;
          m_wdata = cap_wdata;
          m_wstrb = cap_wstrb;
          if (m_ack) begin
            state_nxt = ST_IDLE;
            for (int i = 0; i < int'(N_PORTS); i++) begin
              if (owner == IDX_W'(i)) begin
                s_ack[i]                     = 1'b1;
                s_rdata[i*DATA_W +: DATA_W]  = m_rdata;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_cache_nport_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_iob_cache_nport_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NB = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    s_req;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wdata;
  logic [N*NB-1:0] s_wstrb;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_ack;
  logic            m_req;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [NB-1:0]   m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic            m_ack;

  logic [N-1:0]    f_s_req;
  logic [N*AW-1:0] f_s_addr;
  logic [N*DW-1:0] f_s_wdata;
  logic [N*NB-1:0] f_s_wstrb;
  logic [N*DW-1:0] f_s_rdata;
  logic [N-1:0]    f_s_ack;
  logic            f_m_req;
  logic [AW-1:0]   f_m_addr;
  logic [DW-1:0]   f_m_wdata;
  logic [NB-1:0]   f_m_wstrb;
  logic [DW-1:0]   f_m_rdata;
  logic            f_m_ack;

  int n_checks = 0;
  int n_pass   = 0;

  iob_cache_nport_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ack(s_ack), .m_req(m_req),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .m_ack(m_ack)
  );

  iob_cache_nport_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)
  ) dut_fixed (
    .clk(clk), .rst(rst), .s_req(f_s_req), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_wstrb(f_s_wstrb), .s_rdata(f_s_rdata), .s_ack(f_s_ack), .m_req(f_m_req),
    .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb), .m_rdata(f_m_rdata),
    .m_ack(f_m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Transaction-level reference model.
  bit            mdl_busy;
  int            mdl_owner;
  int            mdl_last;
  logic [AW-1:0] mdl_addr;
  logic [DW-1:0] mdl_wdata;
  logic [NB-1:0] mdl_wstrb;

  logic          exp_mreq;
  logic [AW-1:0] exp_maddr;
  logic [DW-1:0] exp_mwdata;
  logic [NB-1:0] exp_mwstrb;
  logic [N-1:0]  exp_sack;
  logic [N*DW-1:0] exp_srdata;

  function automatic int pick(input logic [N-1:0] req, input int last);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_eval();
    int w;
    exp_mreq = 1'b0; exp_maddr = '0; exp_mwdata = '0; exp_mwstrb = '0;
    exp_sack = '0; exp_srdata = '0;
    if (!rst) begin
      if (!mdl_busy) begin
        w = pick(s_req, mdl_last);
        if (w >= 0) begin
          exp_mreq   = 1'b1;
          exp_maddr  = s_addr[w*AW +: AW];
          exp_mwdata = s_wdata[w*DW +: DW];
          exp_mwstrb = s_wstrb[w*NB +: NB];
        end
      end else begin
        exp_mreq   = ~m_ack;
        exp_maddr  = mdl_addr;
        exp_mwdata = mdl_wdata;
        exp_mwstrb = mdl_wstrb;
        if (m_ack) begin
          exp_sack[mdl_owner] = 1'b1;
          exp_srdata[mdl_owner*DW +: DW] = m_rdata;
        end
      end
    end
  endtask

  task automatic model_commit();
    int w;
    if (rst) begin
      mdl_busy = 0; mdl_owner = 0; mdl_last = N - 1;
      mdl_addr = '0; mdl_wdata = '0; mdl_wstrb = '0;
    end else if (!mdl_busy) begin
      w = pick(s_req, mdl_last);
      if (w >= 0) begin
        mdl_busy  = 1; mdl_owner = w; mdl_last = w;
        mdl_addr  = s_addr[w*AW +: AW];
        mdl_wdata = s_wdata[w*DW +: DW];
        mdl_wstrb = s_wstrb[w*NB +: NB];
      end
    end else if (m_ack) begin
      mdl_busy = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] s);
    s_addr[p*AW +: AW]  = a;
    s_wdata[p*DW +: DW] = d;
    s_wstrb[p*NB +: NB] = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_req = 3'b111; m_ack = 1'b1; m_rdata = 32'hA5A5_A5A5;
    for (int i = 0; i < N; i++) set_port(i, AW'(32'h200 + i), 32'h1111_0000 + i, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++; if (m_req !== 1'b0) $display("FAIL reset_m_req cyc%0d got %0h exp 0", c, m_req); else n_pass++;
      n_checks++; if (s_ack !== 3'b000) $display("FAIL reset_s_ack cyc%0d got %0h exp 0", c, s_ack); else n_pass++;
      n_checks++; if (s_rdata !== '0) $display("FAIL reset_s_rdata cyc%0d got %0h exp 0", c, s_rdata); else n_pass++;
      tick();
    end
    rst = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1) $display("FAIL reset_first_req got %0h exp 1", m_req); else n_pass++;
    n_checks++; if (m_addr !== 30'h200) $display("FAIL reset_first_addr got %0h exp 200", m_addr); else n_pass++;
    tick();
    m_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b001) $display("FAIL reset_first_ack got %0b exp 001", s_ack); else n_pass++;
    tick();
    m_ack = 1'b0; s_req = '0;
  endtask

  task automatic test_single_read();
    set_port(1, 30'h100, 32'h0, 4'h0);
    s_req = 3'b010;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_addr !== 30'h100 || m_wstrb !== 4'h0)
      $display("FAIL single_grant got req=%0h addr=%0h wstrb=%0h exp 1/100/0", m_req, m_addr, m_wstrb); else n_pass++;
    tick();
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b010) $display("FAIL single_ack got %0b exp 010", s_ack); else n_pass++;
    n_checks++; if (s_rdata[63:32] !== 32'hDEAD_BEEF) $display("FAIL single_rdata1 got %0h exp deadbeef", s_rdata[63:32]); else n_pass++;
    n_checks++; if (s_rdata[31:0] !== 32'h0 || s_rdata[95:64] !== 32'h0)
      $display("FAIL single_rdata_others got %0h exp 0 outside port 1", s_rdata); else n_pass++;
    tick();
    m_ack = 1'b0; s_req = '0;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b000 || m_req !== 1'b0) $display("FAIL single_after got ack=%0b req=%0h exp 0/0", s_ack, m_req); else n_pass++;
  endtask

  task automatic test_rr_contention();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_port(i, AW'(32'h200 + i), 32'h0, 4'h0);
    s_req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      m_ack = 1'b0;
      @(negedge clk);
      n_checks++; if (m_req !== 1'b1 || m_addr !== AW'(32'h200 + t % N) || s_ack !== 3'b000)
        $display("FAIL rr_grant t%0d got req=%0h addr=%0h ack=%0b exp 1/%0h/0", t, m_req, m_addr, s_ack, 32'h200 + t % N); else n_pass++;
      tick();
      m_ack = 1'b1; m_rdata = 32'hC0DE_0000 + t;
      @(negedge clk);
      n_checks++; if (s_ack !== 3'(1 << (t % N)) || m_req !== 1'b0)
        $display("FAIL rr_ack t%0d got ack=%0b req=%0h exp %0b/0", t, s_ack, m_req, 3'(1 << (t % N))); else n_pass++;
      tick();
    end
    m_ack = 1'b0; s_req = '0;
  endtask

  task automatic test_fixed_priority();
    f_s_addr = {30'h302, 30'h301, 30'h300};
    f_s_req  = 3'b101;
    for (int t = 0; t < 4; t++) begin
      f_m_ack = 1'b0;
      @(negedge clk);
      n_checks++; if (f_m_req !== 1'b1 || f_m_addr !== 30'h300)
        $display("FAIL fixed_grant t%0d got req=%0h addr=%0h exp 1/300", t, f_m_req, f_m_addr); else n_pass++;
      tick();
      f_m_ack = 1'b1; f_m_rdata = 32'h5A5A_0000 + t;
      @(negedge clk);
      n_checks++; if (f_s_ack !== 3'b001) $display("FAIL fixed_ack t%0d got %0b exp 001", t, f_s_ack); else n_pass++;
      tick();
    end
    f_s_req = 3'b100; f_m_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (f_m_addr !== 30'h302) $display("FAIL fixed_port2_grant got %0h exp 302", f_m_addr); else n_pass++;
    tick();
    f_m_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (f_s_ack !== 3'b100 || f_s_rdata[95:64] !== 32'h5A5A_0003)
      $display("FAIL fixed_port2_ack got ack=%0b rdata=%0h exp 100/5a5a0003", f_s_ack, f_s_rdata[95:64]); else n_pass++;
    tick();
    f_m_ack = 1'b0; f_s_req = '0;
  endtask

  task automatic test_capture_stall();
    set_port(0, 30'h40, 32'h1234_5678, 4'hF);
    s_req = 3'b001;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_wdata !== 32'h1234_5678)
      $display("FAIL cap_grant got req=%0h wdata=%0h exp 1/12345678", m_req, m_wdata); else n_pass++;
    tick();
    set_port(0, 30'h7, 32'hFFFF_0000, 4'h0);
    s_req = 3'b000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (m_req !== 1'b1 || m_addr !== 30'h40 || m_wdata !== 32'h1234_5678 || m_wstrb !== 4'hF || s_ack !== 3'b000)
        $display("FAIL cap_hold cyc%0d got req=%0h addr=%0h wdata=%0h wstrb=%0h ack=%0b exp 1/40/12345678/f/0",
                 c, m_req, m_addr, m_wdata, m_wstrb, s_ack); else n_pass++;
      tick();
    end
    m_ack = 1'b1; m_rdata = 32'h0;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b001 || m_req !== 1'b0) $display("FAIL cap_ack got ack=%0b req=%0h exp 001/0", s_ack, m_req); else n_pass++;
    tick();
    m_ack = 1'b0;
  endtask

  task automatic test_abort();
    for (int i = 0; i < N; i++) set_port(i, AW'(32'h200 + i), 32'h0, 4'h0);
    s_req = 3'b100;
    tick();
    rst = 1'b1; s_req = '0;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b0 || s_ack !== 3'b000) $display("FAIL abort_rst got req=%0h ack=%0b exp 0/0", m_req, s_ack); else n_pass++;
    tick();
    rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b000 || m_req !== 1'b0 || s_rdata !== '0)
      $display("FAIL abort_spurious got ack=%0b req=%0h rdata=%0h exp 0/0/0", s_ack, m_req, s_rdata); else n_pass++;
    tick();
    m_ack = 1'b0; s_req = 3'b111;
    @(negedge clk);
    n_checks++; if (m_req !== 1'b1 || m_addr !== 30'h200) $display("FAIL abort_next_grant got req=%0h addr=%0h exp 1/200", m_req, m_addr); else n_pass++;
    tick();
    m_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ack !== 3'b001) $display("FAIL abort_next_ack got %0b exp 001", s_ack); else n_pass++;
    tick();
    m_ack = 1'b0; s_req = '0;
  endtask

  task automatic test_random();
    rst = 1'b1;
    @(posedge clk); model_commit(); #1;
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 39) == 0);
      s_req = 3'($urandom);
      for (int i = 0; i < N; i++)
        set_port(i, AW'($urandom), $urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
      m_ack   = 1'($urandom);
      m_rdata = $urandom;
      @(negedge clk);
      model_eval();
      n_checks++; if (m_req !== exp_mreq) $display("FAIL rnd_m_req cyc%0d got %0h exp %0h", c, m_req, exp_mreq); else n_pass++;
      n_checks++; if (m_addr !== exp_maddr) $display("FAIL rnd_m_addr cyc%0d got %0h exp %0h", c, m_addr, exp_maddr); else n_pass++;
      n_checks++; if (m_wdata !== exp_mwdata) $display("FAIL rnd_m_wdata cyc%0d got %0h exp %0h", c, m_wdata, exp_mwdata); else n_pass++;
      n_checks++; if (m_wstrb !== exp_mwstrb) $display("FAIL rnd_m_wstrb cyc%0d got %0h exp %0h", c, m_wstrb, exp_mwstrb); else n_pass++;
      n_checks++; if (s_ack !== exp_sack) $display("FAIL rnd_s_ack cyc%0d got %0b exp %0b", c, s_ack, exp_sack); else n_pass++;
      n_checks++; if (s_rdata !== exp_srdata) $display("FAIL rnd_s_rdata cyc%0d got %0h exp %0h", c, s_rdata, exp_srdata); else n_pass++;
      @(posedge clk);
      model_commit();
      #1;
    end
    rst = 1'b0; s_req = '0; m_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_req = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_rdata = '0; m_ack = 1'b0;
    f_s_req = '0; f_s_addr = '0; f_s_wdata = '0; f_s_wstrb = '0;
    f_m_rdata = '0; f_m_ack = 1'b0;
    test_reset();
    test_single_read();
    test_rr_contention();
    test_fixed_priority();
    test_capture_stall();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
